// File: rtl/fft8_frame_ctrl.sv
// Frame controller for the 8-point butterfly datapath: loads 8 samples, waits out the
// datapath latency, captures the results into a local buffer and streams them out.
module fft8_frame_ctrl #(
    parameter int N_PTS    = 8,
    parameter int DATA_W   = 50,
    parameter int PIPE_LAT = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] in_tdata_i,
    input  logic              in_tvalid_i,
    input  logic              in_tlast_i,
    output logic              in_tready_o,
    output logic [DATA_W-1:0] bf_signal_o,
    output logic [2:0]        bf_num_o,
    output logic              bf_flag_o,
    output logic              bf_we_o,
    output logic [2:0]        bf_rd_idx_o,
    input  logic [DATA_W-1:0] bf_result_i,
    output logic [DATA_W-1:0] out_tdata_o,
    output logic [2:0]        out_tidx_o,
    output logic              out_tvalid_o,
    output logic              out_tlast_o,
    input  logic              out_tready_i,
    output logic              frame_err_o,
    output logic              busy_o,
    output logic [1:0]        fsm_state_o
);

    localparam int          IDX_W    = $clog2(N_PTS);
    localparam int          CNT_W    = $clog2(PIPE_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   load_idx_q;
    logic [IDX_W-1:0]   rd_idx_q;
    logic [IDX_W-1:0]   out_idx_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               buf_full_q;
    logic [DATA_W-1:0]  res_buf [N_PTS];
    logic               accept;
    logic               out_hs;

    // Both streams: a beat transfers on a cycle where valid && ready; a source holds
    // its payload stable while valid is high and ready is low.
    assign accept = in_tvalid_i && in_tready_o;
    assign out_hs = out_tvalid_o && out_tready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_tready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_tready_o = 1'b1;
                if (accept) state_d = S_LOAD;
            end
            S_LOAD: begin
                in_tready_o = 1'b1;
                if (accept && load_idx_q == LAST_IDX) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A held result buffer stalls capture; the datapath keeps its state meanwhile.
                if (wait_cnt_q == '0 && !buf_full_q) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (rd_idx_q == LAST_IDX) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            load_idx_q  <= '0;
            wait_cnt_q  <= '0;
            rd_idx_q    <= '0;
            out_idx_q   <= '0;
            buf_full_q  <= 1'b0;
            bf_we_o     <= 1'b0;
            bf_signal_o <= '0;
            bf_num_o    <= '0;
            bf_flag_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            bf_we_o     <= accept;
            bf_flag_o   <= accept && (load_idx_q == LAST_IDX);
            frame_err_o <= accept && (in_tlast_i != (load_idx_q == LAST_IDX));
            if (accept) begin
                bf_signal_o <= in_tdata_i;
                bf_num_o    <= load_idx_q;
                load_idx_q  <= load_idx_q + 1'b1;
            end
            // The count starts in the cycle that carries the slot-7 write.
            if (state_q == S_LOAD && state_d == S_WAIT) begin
                wait_cnt_q <= CNT_W'(PIPE_LAT);
            end else if (state_q == S_WAIT && wait_cnt_q != '0) begin
                wait_cnt_q <= wait_cnt_q - 1'b1;
            end
            if (state_q == S_CAPTURE) begin
                rd_idx_q <= rd_idx_q + 1'b1;
            end
            if (out_hs) begin
                out_idx_q <= out_idx_q + 1'b1;
            end
            if (state_q == S_CAPTURE && rd_idx_q == LAST_IDX) begin
                buf_full_q <= 1'b1;
            end else if (out_hs && out_idx_q == LAST_IDX) begin
                buf_full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == S_CAPTURE) begin
            res_buf[rd_idx_q] <= bf_result_i;
        end
    end

    assign bf_rd_idx_o  = rd_idx_q;
    assign out_tvalid_o = buf_full_q;
    assign out_tdata_o  = buf_full_q ? res_buf[out_idx_q] : '0;
    assign out_tidx_o   = out_idx_q;
    assign out_tlast_o  = buf_full_q && (out_idx_q == LAST_IDX);
    assign busy_o       = (state_q != S_IDLE) || buf_full_q;
    assign fsm_state_o  = state_q;

endmodule
